// File: rtl/tp_gen_ml_if.sv
// Bus interface for the multi-lane test-pattern generator.
// Groups the configuration, the start/stop handshake and the pattern output.
// With TPG_ERR_INJECT_EN defined it also carries err_inj and err_cnt.
interface tp_gen_ml_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    parameter int BURST_W   = 16,
    parameter int PRBS_ORD  = 7
);
    logic [2:0]                  cfg_mode;
    logic [PRBS_ORD-1:0]         cfg_seed;
    logic [BURST_W-1:0]          cfg_burst_len;
    logic                        start;
    logic                        stop;
    logic                        busy;
    logic                        done;
    logic                        out_valid;
    logic [NUM_LANES*LANE_W-1:0] out_data;
`ifdef TPG_ERR_INJECT_EN
    logic                        err_inj;
    logic [7:0]                  err_cnt;

    // Config/control source (scan-chain side, or a testbench).
    modport master (
        output cfg_mode, cfg_seed, cfg_burst_len, start, stop, err_inj,
        input  busy, done, out_valid, out_data, err_cnt
    );

    // Pattern generator side.
    modport slave (
        input  cfg_mode, cfg_seed, cfg_burst_len, start, stop, err_inj,
        output busy, done, out_valid, out_data, err_cnt
    );
`else
    // Config/control source (scan-chain side, or a testbench).
    modport master (
        output cfg_mode, cfg_seed, cfg_burst_len, start, stop,
        input  busy, done, out_valid, out_data
    );

    // Pattern generator side.
    modport slave (
        input  cfg_mode, cfg_seed, cfg_burst_len, start, stop,
        output busy, done, out_valid, out_data
    );
`endif
endinterface

// File: rtl/tp_gen_ml.sv
// Multi-lane test-pattern generator for the ADC backend datapath.
// Modes: 0 IDLE (zeros), 1 STATIC_0, 2 STATIC_1, 3 CNT, 4 PRBS; 5-7 act as IDLE.
// A burst is started by a one-cycle start pulse in S_IDLE, at which point mode,
// seed and burst length are latched. Every RUN cycle carries one valid word.
// All outputs are registered: the word launched by an edge is visible the
// following cycle, so the first valid word follows the start cycle directly.
// PRBS is a Fibonacci LFSR (x^ORD + x^(ORD-1) + 1) advanced NUM_LANES*LANE_W
// steps per cycle; serial bit j lands on out_data[j] (lane 0 LSB first).
// Optional feature macro: TPG_ERR_INJECT_EN adds err_inj / err_cnt. err_inj is
// sampled by the same edge that launches a word and flips bit 0 of lane 0 of
// that word only; the generator state is not touched.
module tp_gen_ml #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    parameter int BURST_W   = 16,
    parameter int PRBS_ORD  = 7
) (
    input  logic       clk,
    input  logic       rst,
    tp_gen_ml_if.slave bus
);
    localparam int DATA_W = NUM_LANES * LANE_W;

    localparam logic [2:0] MODE_STATIC_0 = 3'd1;
    localparam logic [2:0] MODE_STATIC_1 = 3'd2;
    localparam logic [2:0] MODE_CNT      = 3'd3;
    localparam logic [2:0] MODE_PRBS     = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // State and latched configuration
    state_t              state_r;
    state_t              state_s;
    logic [2:0]          mode_r;
    logic [BURST_W-1:0]  len_r;
    logic [BURST_W-1:0]  burst_cnt_r;
    logic [LANE_W-1:0]   cnt_r;
    logic [PRBS_ORD-1:0] lfsr_r;

    // Registered outputs
    logic                busy_r;
    logic                done_r;
    logic                valid_r;
    logic [DATA_W-1:0]   data_r;

    // Combinational helpers
    logic                start_s;
    logic                emit_s;
    logic [2:0]          cur_mode_s;
    logic [LANE_W-1:0]   cur_cnt_s;
    logic [PRBS_ORD-1:0] cur_lfsr_s;
    logic [LANE_W-1:0]   seed_cnt_s;
    logic [PRBS_ORD-1:0] seed_lfsr_s;
    logic [DATA_W-1:0]   cnt_word_s;
    logic [DATA_W-1:0]   prbs_word_s;
    logic [DATA_W-1:0]   word_s;
    logic [DATA_W-1:0]   word_out_s;
    logic [LANE_W-1:0]   cnt_next_s;
    logic [PRBS_ORD-1:0] lfsr_next_s;
    logic [PRBS_ORD-1:0] lfsr_walk_s;
    logic [BURST_W-1:0]  burst_cnt_next_s;

    // Feedback bit of the Fibonacci LFSR for taps ORD and ORD-1.
    function automatic logic lfsr_fb(input logic [PRBS_ORD-1:0] s);
        return s[PRBS_ORD-1] ^ s[PRBS_ORD-2];
    endfunction

    // One LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [PRBS_ORD-1:0] lfsr_step(input logic [PRBS_ORD-1:0] s);
        return {s[PRBS_ORD-2:0], lfsr_fb(s)};
    endfunction

    // CNT start value: low LANE_W bits of the seed, zero-extended when the seed is narrower.
    generate
        if (PRBS_ORD < LANE_W) begin : g_seed_ext
            assign seed_cnt_s = {{(LANE_W-PRBS_ORD){1'b0}}, bus.cfg_seed};
        end else begin : g_seed_trunc
            assign seed_cnt_s = bus.cfg_seed[LANE_W-1:0];
        end
    endgenerate

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    assign seed_lfsr_s = (bus.cfg_seed == {PRBS_ORD{1'b0}}) ? {PRBS_ORD{1'b1}} : bus.cfg_seed;

    // Next-state logic; start in IDLE always wins over a simultaneous stop.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = S_RUN;
                    start_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_s = S_DONE;
                end else if ((len_r != {BURST_W{1'b0}}) && (burst_cnt_r == len_r)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        emit_s = (state_s == S_RUN);
    end

    // Generator source: the live config on the start edge, latched state otherwise.
    always_comb begin
        cur_mode_s = mode_r;
        cur_cnt_s  = cnt_r;
        cur_lfsr_s = lfsr_r;
        if (start_s) begin
            cur_mode_s = bus.cfg_mode;
            cur_cnt_s  = seed_cnt_s;
            cur_lfsr_s = seed_lfsr_s;
        end else begin
            cur_mode_s = mode_r;
            cur_cnt_s  = cnt_r;
            cur_lfsr_s = lfsr_r;
        end
    end

    // CNT word: lane i carries base + i, and the next word starts NUM_LANES higher.
    always_comb begin
        cnt_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_word_s[i*LANE_W +: LANE_W] = cur_cnt_s + LANE_W'(i);
        end
        cnt_next_s = cur_cnt_s + LANE_W'(NUM_LANES);
    end

    // PRBS word: the LFSR is unrolled DATA_W steps, each feedback bit is one serial bit.
    always_comb begin
        prbs_word_s = {DATA_W{1'b0}};
        lfsr_walk_s = cur_lfsr_s;
        for (int j = 0; j < DATA_W; j++) begin
            prbs_word_s[j] = lfsr_fb(lfsr_walk_s);
            lfsr_walk_s    = lfsr_step(lfsr_walk_s);
        end
        lfsr_next_s = lfsr_walk_s;
    end

    // Mode select; IDLE and the reserved codes produce an all-zero word.
    always_comb begin
        word_s = {DATA_W{1'b0}};
        case (cur_mode_s)
            MODE_STATIC_0: word_s = {DATA_W{1'b0}};
            MODE_STATIC_1: word_s = {DATA_W{1'b1}};
            MODE_CNT:      word_s = cnt_word_s;
            MODE_PRBS:     word_s = prbs_word_s;
            default:       word_s = {DATA_W{1'b0}};
        endcase
    end

`ifdef TPG_ERR_INJECT_EN
    logic [7:0] err_cnt_r;

    // Error injection only disturbs the emitted copy of the word.
    always_comb begin
        word_out_s = word_s ^ {{(DATA_W-1){1'b0}}, bus.err_inj};
    end

    // Saturating count of words that carried an injected error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (emit_s && bus.err_inj && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`else
    // Without error injection the pattern goes out untouched.
    always_comb begin
        word_out_s = word_s;
    end
`endif

    // Burst counter saturates at all-ones so continuous bursts never wrap.
    always_comb begin
        if (start_s) begin
            burst_cnt_next_s = BURST_W'(1);
        end else if (&burst_cnt_r) begin
            burst_cnt_next_s = burst_cnt_r;
        end else begin
            burst_cnt_next_s = burst_cnt_r + BURST_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Config latch on start; generator and burst counter advance once per emitted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r      <= 3'd0;
            len_r       <= {BURST_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
            cnt_r       <= {LANE_W{1'b0}};
            lfsr_r      <= {PRBS_ORD{1'b1}};
        end else begin
            if (start_s) begin
                mode_r <= bus.cfg_mode;
                len_r  <= bus.cfg_burst_len;
            end
            if (emit_s) begin
                cnt_r       <= cnt_next_s;
                lfsr_r      <= lfsr_next_s;
                burst_cnt_r <= burst_cnt_next_s;
            end
        end
    end

    // Output registers follow the next state so busy/valid rise with the first word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            busy_r  <= (state_s == S_RUN);
            done_r  <= (state_s == S_DONE);
            valid_r <= emit_s;
            data_r  <= emit_s ? word_out_s : {DATA_W{1'b0}};
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = valid_r;
    assign bus.out_data  = data_r;

endmodule
